// File: rtl/bsg_link_downstream_token_gen.sv
// Receive-side end of the link credit protocol: buffers IO flits, hands them to the core,
// and toggles token_o every 2^lg dequeues. Optional overflow flag: BSG_LINK_TOKEN_OVERFLOW_CHECK_EN.
module bsg_link_downstream_token_gen #(
    parameter int width_p                         = 16,
    parameter int fifo_els_p                      = 16,
    parameter int lg_credit_to_token_decimation_p = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               io_valid_i,
    input  logic [width_p-1:0] io_data_i,
    output logic               core_valid_o,
    output logic [width_p-1:0] core_data_o,
    input  logic               core_yumi_i,
    output logic               token_o,
    output logic [7:0]         token_cnt_o,
    output logic               overflow_o
);

    localparam int ptr_w = $clog2(fifo_els_p);
    localparam int cnt_w = lg_credit_to_token_decimation_p;
    localparam logic [ptr_w:0] els_lp = (ptr_w + 1)'(fifo_els_p);

    logic [width_p-1:0] mem_r [fifo_els_p];
    logic [ptr_w-1:0]   rd_ptr_r;
    logic [ptr_w-1:0]   wr_ptr_r;
    logic [ptr_w:0]     occ_r;
    logic [cnt_w-1:0]   deq_cnt_r;
    logic               token_r;
    logic [7:0]         token_cnt_r;

    logic full;
    logic deq;
    logic enq;
    logic token_wrap;

    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign full       = (occ_r == els_lp);
    assign deq        = core_yumi_i & core_valid_o;
    assign enq        = io_valid_i & (~full | deq);
    assign token_wrap = deq & (&deq_cnt_r);

    assign core_valid_o = (occ_r != '0);
    assign core_data_o  = mem_r[rd_ptr_r];
    assign token_o      = token_r;
    assign token_cnt_o  = token_cnt_r;

    always_ff @(posedge clk) begin
        if (enq && !rst) begin
            mem_r[wr_ptr_r] <= io_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            occ_r    <= '0;
        end else begin
            if (enq) begin
                wr_ptr_r <= wr_ptr_r + 1'b1;
            end
            if (deq) begin
                rd_ptr_r <= rd_ptr_r + 1'b1;
            end
            case ({enq, deq})
                2'b10:   occ_r <= occ_r + 1'b1;
                2'b01:   occ_r <= occ_r - 1'b1;
                default: occ_r <= occ_r;
            endcase
        end
    end

    // Partial dequeue counts are held until enough dequeues complete a token.
    always_ff @(posedge clk) begin
        if (rst) begin
            deq_cnt_r   <= '0;
            token_r     <= 1'b0;
            token_cnt_r <= '0;
        end else begin
            if (deq) begin
                deq_cnt_r <= deq_cnt_r + 1'b1;
            end
            if (token_wrap) begin
                token_r     <= ~token_r;
                token_cnt_r <= token_cnt_r + 8'd1;
            end
        end
    end

`ifdef BSG_LINK_TOKEN_OVERFLOW_CHECK_EN
    logic overflow_r;
    logic dropped;

    assign dropped    = io_valid_i & full & ~deq;
    assign overflow_o = overflow_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_r <= 1'b0;
        end else if (dropped) begin
            overflow_r <= 1'b1;
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!rst && dropped) begin
            $warning("bsg_link_downstream_token_gen: flit dropped on full buffer, wr_ptr=%0d", wr_ptr_r);
        end
    end
`endif
`else
    assign overflow_o = 1'b0;
`endif

endmodule

// File: tb/tb_bsg_link_downstream_token_gen.sv
// Scoreboard bench for bsg_link_downstream_token_gen: stimulus pushes expected flits,
// a negedge monitor pops and compares on every core dequeue.
module tb_bsg_link_downstream_token_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        io_valid_i = 1'b0;
    logic [15:0] io_data_i = '0;
    logic        core_valid_o;
    logic [15:0] core_data_o;
    logic        core_yumi_i = 1'b0;
    logic        token_o;
    logic [7:0]  token_cnt_o;
    logic        overflow_o;

    int total = 0;
    int bad   = 0;
    logic [15:0] exp_q [$];

`ifdef BSG_LINK_TOKEN_OVERFLOW_CHECK_EN
    localparam logic exp_ovf = 1'b1;
`else
    localparam logic exp_ovf = 1'b0;
`endif

    bsg_link_downstream_token_gen #(
        .width_p(16),
        .fifo_els_p(16),
        .lg_credit_to_token_decimation_p(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .io_valid_i(io_valid_i),
        .io_data_i(io_data_i),
        .core_valid_o(core_valid_o),
        .core_data_o(core_data_o),
        .core_yumi_i(core_yumi_i),
        .token_o(token_o),
        .token_cnt_o(token_cnt_o),
        .overflow_o(overflow_o)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // One cycle of stimulus; push_exp records a flit the bench knows will be accepted.
    task automatic applyStimulus(input logic v, input logic [15:0] d, input logic y, input logic push_exp);
        io_valid_i  = v;
        io_data_i   = d;
        core_yumi_i = y;
        if (push_exp) exp_q.push_back(d);
        @(posedge clk);
        #1;
        io_valid_i  = 1'b0;
        core_yumi_i = 1'b0;
    endtask

    task automatic doReset(input logic v, input logic y);
        rst         = 1'b1;
        io_valid_i  = v;
        io_data_i   = 16'hBEEF;
        core_yumi_i = y;
        @(posedge clk);
        #1;
        rst         = 1'b0;
        io_valid_i  = 1'b0;
        core_yumi_i = 1'b0;
        exp_q.delete();
    endtask

    // Monitor: every real dequeue is compared against the head of the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && core_valid_o && core_yumi_i) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("[TB] FAIL deq_unexpected: got %h expected no flit", core_data_o);
                end else begin
                    logic [15:0] e;
                    e = exp_q.pop_front();
                    if (core_data_o !== e) begin
                        bad++;
                        $display("[TB] FAIL deq_data: got %h expected %h", core_data_o, e);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Reset held for two cycles.
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("rst_valid", {15'd0, core_valid_o}, 16'd0);
        checkOutput("rst_token", {15'd0, token_o}, 16'd0);
        checkOutput("rst_token_cnt", {8'd0, token_cnt_o}, 16'd0);
        checkOutput("rst_overflow", {15'd0, overflow_o}, 16'd0);

        // Single flit latency and drain.
        applyStimulus(1'b1, 16'hA5A5, 1'b0, 1'b1);
        checkOutput("single_valid", {15'd0, core_valid_o}, 16'd1);
        checkOutput("single_data", core_data_o, 16'hA5A5);
        applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
        checkOutput("single_empty", {15'd0, core_valid_o}, 16'd0);

        // Token decimation, with yumis on an empty FIFO that must not count.
        doReset(1'b0, 1'b0);
        applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
        applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 16'(i), 1'b0, 1'b1);
        for (int i = 0; i < 7; i++) applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
        checkOutput("tok_seven", {15'd0, token_o}, 16'd0);
        applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
        checkOutput("tok_first", {15'd0, token_o}, 16'd1);
        checkOutput("tok_first_cnt", {8'd0, token_cnt_o}, 16'd1);
        for (int i = 8; i < 16; i++) applyStimulus(1'b1, 16'(i), 1'b0, 1'b1);
        for (int i = 0; i < 7; i++) applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
        checkOutput("tok_hold", {15'd0, token_o}, 16'd1);
        applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
        checkOutput("tok_second", {15'd0, token_o}, 16'd0);
        checkOutput("tok_second_cnt", {8'd0, token_cnt_o}, 16'd2);

        // Full plus simultaneous enqueue/dequeue.
        doReset(1'b0, 1'b0);
        for (int i = 0; i < 16; i++) applyStimulus(1'b1, 16'h1000 + 16'(i), 1'b0, 1'b1);
        applyStimulus(1'b1, 16'h00FF, 1'b1, 1'b1);
        checkOutput("full_sim_overflow", {15'd0, overflow_o}, 16'd0);
        for (int i = 0; i < 16; i++) applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
        checkOutput("full_sim_drained", {15'd0, core_valid_o}, 16'd0);
        checkOutput("full_sim_token_cnt", {8'd0, token_cnt_o}, 16'd2);

        // Write into a full FIFO with no dequeue is dropped.
        doReset(1'b0, 1'b0);
        for (int i = 0; i < 16; i++) applyStimulus(1'b1, 16'h2000 + 16'(i), 1'b0, 1'b1);
        applyStimulus(1'b1, 16'hDEAD, 1'b0, 1'b0);
        checkOutput("ovf_flag", {15'd0, overflow_o}, {15'd0, exp_ovf});
        for (int i = 0; i < 16; i++) applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
        checkOutput("ovf_drained", {15'd0, core_valid_o}, 16'd0);
        applyStimulus(1'b0, 16'h0, 1'b0, 1'b0);
        checkOutput("ovf_sticky", {15'd0, overflow_o}, {15'd0, exp_ovf});
        doReset(1'b0, 1'b0);
        checkOutput("ovf_cleared", {15'd0, overflow_o}, 16'd0);

        // Reset mid-stream, with competing valid and yumi during reset.
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 16'h3000 + 16'(i), 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
        doReset(1'b1, 1'b1);
        checkOutput("mid_rst_valid", {15'd0, core_valid_o}, 16'd0);
        checkOutput("mid_rst_token_cnt", {8'd0, token_cnt_o}, 16'd0);
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 16'h4000 + 16'(i), 1'b0, 1'b1);
        for (int i = 0; i < 7; i++) applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
        checkOutput("mid_rst_seven", {15'd0, token_o}, 16'd0);
        applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
        checkOutput("mid_rst_token", {15'd0, token_o}, 16'd1);
        checkOutput("mid_rst_cnt", {8'd0, token_cnt_o}, 16'd1);

        applyStimulus(1'b0, 16'h0, 1'b0, 1'b0);
        checkOutput("scoreboard_empty", 16'(exp_q.size()), 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
